// File: rtl/mont_exp_ctrl_if.sv
// Purpose : bundles the request/response and multiplier-facing signals of mont_exp_ctrl.
// Latency : n/a (wiring only).
// Backpressure: none; start is a one-cycle request that the sequencer samples only in IDLE.
//
// Ports (slave = sequencer side):
//   start, len, base, exponent, modulus, r2 : operation request from the register block
//   busy, done, result                      : operation status and final value
//   mm_start, mm_len, mm_a, mm_b, mm_mod    : command to the Montgomery multiplier
//   mm_done, mm_res                         : multiplier completion pulse and product
interface mont_exp_ctrl_if #(
  parameter int EXP_W = 32,
  parameter int DW    = 32
);
  logic             start;
  logic [7:0]       len;
  logic [DW-1:0]    base;
  logic [EXP_W-1:0] exponent;
  logic [DW-1:0]    modulus;
  logic [DW-1:0]    r2;
  logic             busy;
  logic             done;
  logic [DW-1:0]    result;
  logic             mm_start;
  logic [7:0]       mm_len;
  logic [DW-1:0]    mm_a;
  logic [DW-1:0]    mm_b;
  logic [DW-1:0]    mm_mod;
  logic             mm_done;
  logic [DW-1:0]    mm_res;

  // Sequencer view.
  modport slave (
    input  start, len, base, exponent, modulus, r2, mm_done, mm_res,
    output busy, done, result, mm_start, mm_len, mm_a, mm_b, mm_mod
  );

  // Environment view: request source plus the multiplier.
  modport master (
    output start, len, base, exponent, modulus, r2, mm_done, mm_res,
    input  busy, done, result, mm_start, mm_len, mm_a, mm_b, mm_mod
  );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Purpose : modular exponentiation base^exponent mod N by square-and-multiply over one shared Montgomery multiplier.
// Latency : data dependent; 3 + bitlen(exp) + popcount(exp) multiplications plus up to EXP_W scan cycles.
// Backpressure: start ignored while busy; each multiplication waits for mm_done before the next mm_start.
//
// Ports:
//   clk, rstn : clock and asynchronous active-low reset (shared with the multiplier)
//   bus       : mont_exp_ctrl_if.slave -- request (start/len/base/exponent/modulus/r2),
//               status (busy/done/result) and multiplier command/response (mm_*)
module mont_exp_ctrl #(
  parameter int EXP_W = 32,
  parameter int DW    = 32
) (
  input  logic           clk,
  input  logic           rstn,
  mont_exp_ctrl_if.slave bus
);

  localparam int            IW      = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(EXP_W - 1);
  localparam logic [DW-1:0] ONE     = DW'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_TOB,   // bm = mont(base, r2): base into Montgomery domain
    S_TOX,   // x  = mont(1, r2) = R mod N: accumulator starts at Montgomery one
    S_SCAN,  // skip leading zero exponent bits
    S_SQR,   // x = mont(x, x)
    S_MUL,   // x = mont(x, bm)
    S_NEXT,  // advance bit index
    S_FROM,  // x = mont(x, 1): leave Montgomery domain
    S_FIX    // final conditional subtraction
  } state_t;

  state_t           state;
  logic             wait_q;     // 0: issue phase, 1: waiting for mm_done
  logic [IW-1:0]    idx;
  logic [7:0]       len_q;
  logic [DW-1:0]    base_q;
  logic [DW-1:0]    mod_q;
  logic [DW-1:0]    r2_q;
  logic [EXP_W-1:0] exp_q;
  logic [DW-1:0]    x_q;
  logic [DW-1:0]    bm_q;

  logic             busy_q;
  logic             done_q;
  logic [DW-1:0]    result_q;
  logic             mm_start_q;
  logic [DW-1:0]    mm_a_q;
  logic [DW-1:0]    mm_b_q;

  logic [DW-1:0]    op_a;
  logic [DW-1:0]    op_b;
  logic [DW-1:0]    x_fix;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.mm_start = mm_start_q;
  assign bus.mm_a     = mm_a_q;
  assign bus.mm_b     = mm_b_q;
  // Length and modulus are latched at start, so they stay constant for the whole operation.
  assign bus.mm_len   = len_q;
  assign bus.mm_mod   = mod_q;

  // Operand selection for the multiplication owned by the current state.
  always_comb begin
    op_a = x_q;
    op_b = x_q;
    case (state)
      S_TOB: begin
        op_a = base_q;
        op_b = r2_q;
      end
      S_TOX: begin
        op_a = ONE;
        op_b = r2_q;
      end
      S_MUL:  op_b = bm_q;
      S_FROM: op_b = ONE;
      default: ;
    endcase
  end

  // The multiplier output may be unreduced; one subtraction brings it into [0, N-1].
  assign x_fix = (x_q >= mod_q) ? (x_q - mod_q) : x_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      wait_q     <= 1'b0;
      idx        <= '0;
      len_q      <= '0;
      base_q     <= '0;
      mod_q      <= '0;
      r2_q       <= '0;
      exp_q      <= '0;
      x_q        <= '0;
      bm_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      mm_start_q <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
    end else begin
      done_q     <= 1'b0;
      mm_start_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            len_q  <= bus.len;
            base_q <= bus.base;
            exp_q  <= bus.exponent;
            mod_q  <= bus.modulus;
            r2_q   <= bus.r2;
            idx    <= IDX_TOP;
            wait_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= S_TOB;
          end
        end

        S_TOB, S_TOX, S_SQR, S_MUL, S_FROM: begin
          if (!wait_q) begin
            // Issue: operands are registered together with the single start pulse
            // and then held until the multiplier answers.
            mm_a_q     <= op_a;
            mm_b_q     <= op_b;
            mm_start_q <= 1'b1;
            wait_q     <= 1'b1;
          end else if (bus.mm_done) begin
            wait_q <= 1'b0;
            if (state == S_TOB) begin
              bm_q <= bus.mm_res;
            end else begin
              x_q <= bus.mm_res;
            end
            case (state)
              S_TOB:   state <= S_TOX;
              S_TOX:   state <= S_SCAN;
              S_SQR:   state <= exp_q[idx] ? S_MUL : S_NEXT;
              S_MUL:   state <= S_NEXT;
              default: state <= S_FIX;   // S_FROM
            endcase
          end
        end

        S_SCAN: begin
          // Leading zeros would only square Montgomery one, so skip them.
          if (exp_q[idx]) begin
            state <= S_SQR;
          end else if (idx == '0) begin
            state <= S_FROM;
          end else begin
            idx <= idx - 1'b1;
          end
        end

        S_NEXT: begin
          if (idx == '0) begin
            state <= S_FROM;
          end else begin
            idx   <= idx - 1'b1;
            state <= S_SQR;
          end
        end

        S_FIX: begin
          result_q <= x_fix;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Purpose : self-checking bench for mont_exp_ctrl with a behavioural Montgomery multiplier.
// Latency : multiplier model answers 1..4 cycles after each mm_start.
// Backpressure: exercised via start-while-busy and variable multiplier delay.
module tb_mont_exp_ctrl;
  localparam int EXP_W = 32;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mont_exp_ctrl_if #(.EXP_W(EXP_W), .DW(DW)) ifc ();

  mont_exp_ctrl #(.EXP_W(EXP_W), .DW(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected result and expected multiplication count per accepted start.
  logic [DW-1:0] res_q[$];
  int            cnt_q[$];

  // Multiplier model state.
  bit            pend;
  int            dly;
  int            starts_seen;
  logic [DW-1:0] held_a, held_b, mval;
  bit            force_last;
  logic [7:0]    cur_len;
  logic [DW-1:0] cur_mod;
  int            cur_nm;
  logic [DW-1:0] prev_res;

  function automatic logic [DW-1:0] mont_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] n, input logic [7:0] l);
    logic [127:0] t;
    t = 128'(a) * 128'(b);
    for (int i = 0; i < int'(l); i++) begin
      if (t[0]) t = t + 128'(n);
      t = t >> 1;
    end
    t = t % 128'(n);
    return t[DW-1:0];
  endfunction

  function automatic int nmults(input logic [EXP_W-1:0] e);
    int bl;
    int pc;
    bl = 0;
    pc = 0;
    for (int i = 0; i < EXP_W; i++) begin
      if (e[i]) begin
        pc++;
        bl = i + 1;
      end
    end
    return 3 + bl + pc;
  endfunction

  // Behavioural multiplier: sees mm_start just after the edge, answers after a random delay.
  initial begin : mult_model
    ifc.mm_done = 1'b0;
    ifc.mm_res  = '0;
    pend        = 0;
    dly         = 0;
    starts_seen = 0;
    held_a      = '0;
    held_b      = '0;
    mval        = '0;
    forever begin
      @(posedge clk);
      #1;
      ifc.mm_done = 1'b0;
      if (!rstn) begin
        pend        = 0;
        starts_seen = 0;
      end else if (pend) begin
        checks++;
        if (ifc.mm_start !== 1'b0 || ifc.mm_a !== held_a || ifc.mm_b !== held_b ||
            ifc.mm_len !== cur_len || ifc.mm_mod !== cur_mod) begin
          errors++;
          $display("FAIL wait_phase: start=%0b a=%h b=%h len=%0d mod=%h, required start=0 a=%h b=%h len=%0d mod=%h",
                   ifc.mm_start, ifc.mm_a, ifc.mm_b, ifc.mm_len, ifc.mm_mod,
                   held_a, held_b, cur_len, cur_mod);
        end
        if (dly == 0) begin
          ifc.mm_done = 1'b1;
          ifc.mm_res  = mval;
          pend        = 0;
        end else begin
          dly--;
        end
      end else if (ifc.mm_start === 1'b1) begin
        starts_seen++;
        checks++;
        if (ifc.mm_len !== cur_len || ifc.mm_mod !== cur_mod) begin
          errors++;
          $display("FAIL issue_operands: len=%0d mod=%h, required len=%0d mod=%h",
                   ifc.mm_len, ifc.mm_mod, cur_len, cur_mod);
        end
        held_a = ifc.mm_a;
        held_b = ifc.mm_b;
        mval   = mont_ref(held_a, held_b, cur_mod, cur_len);
        if (force_last && starts_seen == cur_nm) mval = cur_mod;
        dly  = $urandom_range(0, 3);
        pend = 1;
      end
    end
  end

  // Output monitor: scoreboard pop on done, plus cycle invariants.
  initial begin : monitor
    logic [DW-1:0] exp_r;
    int            exp_n;
    prev_res = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_res = '0;
      end else begin
        checks++;
        if (ifc.busy === 1'b1 && ifc.done === 1'b1) begin
          errors++;
          $display("FAIL busy_done_overlap: busy=1 done=1, required not both");
        end
        if (ifc.done === 1'b1) begin
          checks++;
          if (res_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: result=%h, required no done", ifc.result);
          end else begin
            exp_r = res_q.pop_front();
            exp_n = cnt_q.pop_front();
            if (ifc.result !== exp_r) begin
              errors++;
              $display("FAIL result: got %h, required %h", ifc.result, exp_r);
            end
            checks++;
            if (starts_seen != exp_n) begin
              errors++;
              $display("FAIL mm_start_count: got %0d, required %0d", starts_seen, exp_n);
            end
          end
          starts_seen = 0;
        end else begin
          checks++;
          if (ifc.result !== prev_res) begin
            errors++;
            $display("FAIL result_hold: got %h, required %h", ifc.result, prev_res);
          end
        end
        prev_res = ifc.result;
      end
    end
  end

  task automatic issue_start(input logic [DW-1:0] b, input logic [EXP_W-1:0] e,
                             input logic [DW-1:0] n, input logic [7:0] l,
                             input logic [DW-1:0] r2v, input logic [DW-1:0] expres);
    @(negedge clk);
    ifc.base     = b;
    ifc.exponent = e;
    ifc.modulus  = n;
    ifc.len      = l;
    ifc.r2       = r2v;
    ifc.start    = 1'b1;
    cur_len      = l;
    cur_mod      = n;
    cur_nm       = nmults(e);
    res_q.push_back(expres);
    cnt_q.push_back(nmults(e));
    @(negedge clk);
    ifc.start = 1'b0;
    checks++;
    if (ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b, required 1", ifc.busy);
    end
  endtask

  // Waits for done; reports whether it arrived and how many earlier cycles had busy low.
  task automatic wait_done(input int max, output bit ok, output int busy_low);
    ok = 0;
    busy_low = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (ifc.done === 1'b1) begin
        ok = 1;
        break;
      end
      if (ifc.busy !== 1'b1) busy_low++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.mm_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b mm_start=%b, required 0 0 0",
               ifc.busy, ifc.done, ifc.mm_start);
    end
    checks++;
    if (ifc.result !== '0 || ifc.mm_a !== '0 || ifc.mm_b !== '0 ||
        ifc.mm_mod !== '0 || ifc.mm_len !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: result=%h a=%h b=%h mod=%h len=%0d, required all 0",
               ifc.result, ifc.mm_a, ifc.mm_b, ifc.mm_mod, ifc.mm_len);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b, required 0", ifc.busy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int bl;
    issue_start(32'd5, 32'd3, 32'd13, 8'd4, 32'd9, 32'd8);
    wait_done(1000, ok, bl);
    checks++;
    if (!ok || bl != 0) begin
      errors++;
      $display("FAIL basic_done: done_seen=%0b busy_low_cycles=%0d, required 1 and 0", ok, bl);
    end
    checks++;
    if (ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_drop: got %b, required 0", ifc.busy);
    end
  endtask

  task automatic test_exp_zero();
    bit ok;
    int bl;
    int nd;
    int t_done;
    int gap;
    issue_start(32'd5, 32'd0, 32'd13, 8'd4, 32'd9, 32'd1);
    nd = 0;
    t_done = -1;
    gap = -1;
    for (int k = 0; k < 500 && gap < 0; k++) begin
      @(negedge clk);
      if (nd == 2 && ifc.mm_start === 1'b1) gap = k - t_done;
      if (ifc.mm_done === 1'b1) begin
        nd++;
        if (nd == 2) t_done = k;
      end
    end
    // EXP_W scan cycles, plus the capture edge and the issue cycle of the final multiplication.
    checks++;
    if (gap != EXP_W + 2) begin
      errors++;
      $display("FAIL scan_length: gap=%0d, required %0d", gap, EXP_W + 2);
    end
    wait_done(1000, ok, bl);
    checks++;
    if (!ok || bl != 0) begin
      errors++;
      $display("FAIL exp0_done: done_seen=%0b busy_low_cycles=%0d, required 1 and 0", ok, bl);
    end
  endtask

  task automatic test_exp_one_fix();
    bit ok;
    int bl;
    issue_start(32'd7, 32'd1, 32'd13, 8'd4, 32'd9, 32'd7);
    wait_done(1000, ok, bl);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL exp1_done: done_seen=%0b, required 1", ok);
    end
    // Last multiplication returns exactly N, which the final correction must fold to 0.
    force_last = 1;
    issue_start(32'd7, 32'd1, 32'd13, 8'd4, 32'd9, 32'd0);
    wait_done(1000, ok, bl);
    force_last = 0;
    checks++;
    if (!ok || bl != 0) begin
      errors++;
      $display("FAIL fix_done: done_seen=%0b busy_low_cycles=%0d, required 1 and 0", ok, bl);
    end
  endtask

  task automatic test_large();
    bit ok;
    int bl;
    issue_start(32'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 8'd32, 32'd25, 32'd1);
    wait_done(5000, ok, bl);
    checks++;
    if (!ok || bl != 0) begin
      errors++;
      $display("FAIL large_done: done_seen=%0b busy_low_cycles=%0d, required 1 and 0", ok, bl);
    end
  endtask

  task automatic test_start_busy();
    bit ok;
    int bl;
    int stray;
    issue_start(32'd5, 32'd3, 32'd13, 8'd4, 32'd9, 32'd8);
    repeat (4) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_op: got %b, required 1", ifc.busy);
    end
    ifc.base     = 32'd2;
    ifc.exponent = 32'd5;
    ifc.modulus  = 32'd11;
    ifc.len      = 8'd5;
    ifc.r2       = 32'd1;
    ifc.start    = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done(1000, ok, bl);
    checks++;
    if (!ok || bl != 0) begin
      errors++;
      $display("FAIL busy_start_done: done_seen=%0b busy_low_cycles=%0d, required 1 and 0", ok, bl);
    end
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ifc.busy !== 1'b0 || ifc.mm_start !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL ignored_start: active_cycles=%0d, required 0", stray);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bl;
    bit seen;
    issue_start(32'd5, 32'd3, 32'd13, 8'd4, 32'd9, 32'd8);
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (pend) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reach_wait: seen=%0b, required 1", seen);
    end
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.mm_start !== 1'b0 || ifc.result !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b mm_start=%b result=%h, required 0 0 0 0",
               ifc.busy, ifc.done, ifc.mm_start, ifc.result);
    end
    res_q.delete();
    cnt_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    issue_start(32'd5, 32'd3, 32'd13, 8'd4, 32'd9, 32'd8);
    wait_done(1000, ok, bl);
    checks++;
    if (!ok || bl != 0) begin
      errors++;
      $display("FAIL post_reset_done: done_seen=%0b busy_low_cycles=%0d, required 1 and 0", ok, bl);
    end
  endtask

  initial begin : main
    ifc.start    = 1'b0;
    ifc.len      = '0;
    ifc.base     = '0;
    ifc.exponent = '0;
    ifc.modulus  = '0;
    ifc.r2       = '0;
    force_last   = 0;
    cur_len      = '0;
    cur_mod      = '0;
    cur_nm       = 0;
    test_reset();
    test_basic();
    test_exp_zero();
    test_exp_one_fix();
    test_large();
    test_start_busy();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (res_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d outstanding, required 0", res_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
